// File: rtl/mem_arb_if.sv
// ---------------------------------------------------------------------------
// mem_arb_if.sv
//
// Bus bundles used around the mem_arb block.
//
//   mem_arb_req_if : one requester port of the arbiter.
//     valid  requester has a transaction pending
//     wr_rd  1 = write, 0 = read
//     addr   word address
//     wdata  write data
//     rdata  read data, valid while ready=1, held until the next read
//     ready  one-cycle completion pulse
//     modport master = bus master side, modport slave = arbiter side
//
//   mem_arb_mem_if : access channel from the arbiter to the memory.
//     m_valid  single-cycle access strobe
//     m_wr_rd  1 = write, 0 = read
//     m_addr   word address
//     m_wdata  write data
//     m_rdata  registered read data from the memory
//     m_ready  completion from the memory
//     modport master = arbiter side, modport slave = memory side
// ---------------------------------------------------------------------------
interface mem_arb_req_if #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 5
);
   logic                  valid;
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic [WIDTH-1:0]      rdata;
   logic                  ready;

   modport master (output valid, wr_rd, addr, wdata, input  rdata, ready);
   modport slave  (input  valid, wr_rd, addr, wdata, output rdata, ready);
endinterface

interface mem_arb_mem_if #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 5
);
   logic                  m_valid;
   logic                  m_wr_rd;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [WIDTH-1:0]      m_wdata;
   logic [WIDTH-1:0]      m_rdata;
   logic                  m_ready;

   modport master (output m_valid, m_wr_rd, m_addr, m_wdata, input  m_rdata, m_ready);
   modport slave  (input  m_valid, m_wr_rd, m_addr, m_wdata, output m_rdata, m_ready);
endinterface

// File: rtl/mem_arb.sv
// ---------------------------------------------------------------------------
// mem_arb.sv
//
// Two-requester arbiter/sequencer in front of a single-port valid/ready
// memory. One transaction at a time: grant a port, pulse m_valid for one
// cycle, wait for m_ready, return a one-cycle ready pulse (plus read data
// for reads) to the granted port, then spend one DONE cycle so the
// requester can retire its request before the next arbitration.
//
// Ports:
//   clk    rising-edge clock
//   res    asynchronous active-low reset
//   s0,s1  requester ports (mem_arb_req_if.slave)
//   m      memory access channel (mem_arb_mem_if.master)
//   busy   high in any state except IDLE
//   grant  index of the port owning the current or last transaction
//
// Build option:
//   MEM_ARB_RR_EN  defined     : ties go to the port not served last.
//                  not defined : port 0 always wins ties (port 1 may starve).
// ---------------------------------------------------------------------------
module mem_arb #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          res,
   mem_arb_req_if.slave  s0,
   mem_arb_req_if.slave  s1,
   mem_arb_mem_if.master m,
   output logic          busy,
   output logic          grant
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e                state_q,   state_d;
   logic                  m_valid_q, m_valid_d;
   logic                  m_wr_rd_q, m_wr_rd_d;
   logic [ADDR_WIDTH-1:0] m_addr_q,  m_addr_d;
   logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
   logic [WIDTH-1:0]      s0_rdata_q, s0_rdata_d;
   logic [WIDTH-1:0]      s1_rdata_q, s1_rdata_d;
   logic                  s0_ready_q, s0_ready_d;
   logic                  s1_ready_q, s1_ready_d;
   logic                  grant_q,   grant_d;
   logic                  busy_q,    busy_d;
   logic                  sel;       // port that would win arbitration now
`ifdef MEM_ARB_RR_EN
   logic                  last_q,    last_d;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave a value unassigned (no latch).
      state_d    = state_q;
      m_valid_d  = 1'b0;
      m_wr_rd_d  = m_wr_rd_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      s0_rdata_d = s0_rdata_q;
      s1_rdata_d = s1_rdata_q;
      s0_ready_d = 1'b0;
      s1_ready_d = 1'b0;
      grant_d    = grant_q;
      sel        = s1.valid;
`ifdef MEM_ARB_RR_EN
      last_d     = last_q;
`endif

      // A lone request wins outright; only a tie consults the rule.
      if (s0.valid && s1.valid) begin
`ifdef MEM_ARB_RR_EN
         sel = ~last_q;
`else
         sel = 1'b0;
`endif
      end

      case (state_q)
         IDLE: begin
            if (s0.valid || s1.valid) begin
               grant_d   = sel;
               m_valid_d = 1'b1;
               m_wr_rd_d = sel ? s1.wr_rd : s0.wr_rd;
               m_addr_d  = sel ? s1.addr  : s0.addr;
               m_wdata_d = sel ? s1.wdata : s0.wdata;
`ifdef MEM_ARB_RR_EN
               last_d    = sel;
`endif
               state_d   = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (m.m_ready) begin
               if (!m_wr_rd_q) begin
                  if (grant_q) s1_rdata_d = m.m_rdata;
                  else         s0_rdata_d = m.m_rdata;
               end
               s0_ready_d = ~grant_q;
               s1_ready_d =  grant_q;
               state_d    = DONE;
            end
         end
         // Valids are ignored here: the requester is still looking at ready.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q    <= IDLE;
         m_valid_q  <= 1'b0;
         m_wr_rd_q  <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         s0_rdata_q <= '0;
         s1_rdata_q <= '0;
         s0_ready_q <= 1'b0;
         s1_ready_q <= 1'b0;
         grant_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_q     <= 1'b1;   // port 0 wins the first tie
`endif
      end else begin
         // NOTE: non-blocking assignments so every register updates from
         // the values of the previous cycle, independent of statement order.
         state_q    <= state_d;
         m_valid_q  <= m_valid_d;
         m_wr_rd_q  <= m_wr_rd_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         s0_rdata_q <= s0_rdata_d;
         s1_rdata_q <= s1_rdata_d;
         s0_ready_q <= s0_ready_d;
         s1_ready_q <= s1_ready_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
`ifdef MEM_ARB_RR_EN
         last_q     <= last_d;
`endif
      end
   end

   assign m.m_valid = m_valid_q;
   assign m.m_wr_rd = m_wr_rd_q;
   assign m.m_addr  = m_addr_q;
   assign m.m_wdata = m_wdata_q;
   assign s0.rdata  = s0_rdata_q;
   assign s1.rdata  = s1_rdata_q;
   assign s0.ready  = s0_ready_q;
   assign s1.ready  = s1_ready_q;
   assign busy      = busy_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arb.sv
`timescale 1ns/1ps
module tb_mem_arb;

   localparam int WIDTH = 16;
   localparam int DEPTH = 32;
   localparam int AW    = $clog2(DEPTH);

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [WIDTH-1:0] data;
   } txn_t;

   typedef struct packed {
      logic          port;
      logic          wr;
      logic [AW-1:0] addr;
      logic [WIDTH-1:0] data;
   } issue_t;

   logic clk = 1'b0;
   logic res = 1'b0;
   logic busy;
   logic grant;

   mem_arb_req_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) s0_if ();
   mem_arb_req_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) s1_if ();
   mem_arb_mem_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) m_if ();

   mem_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .res   (res),
      .s0    (s0_if),
      .s1    (s1_if),
      .m     (m_if),
      .busy  (busy),
      .grant (grant)
   );

   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // ---------------- memory model (registered read, valid/ready) ----------------
   logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
   int   mem_delay = 0;
   int   mem_cnt;
   logic mem_pend;

   always @(posedge clk or negedge res) begin
      if (!res) begin
         m_if.m_ready <= 1'b0;
         m_if.m_rdata <= '0;
         mem_pend     <= 1'b0;
         mem_cnt      <= 0;
      end else begin
         m_if.m_ready <= 1'b0;
         if (m_if.m_valid) begin
            if (m_if.m_wr_rd) mem[m_if.m_addr] <= m_if.m_wdata;
            else              m_if.m_rdata     <= mem[m_if.m_addr];
            if (mem_delay == 0) m_if.m_ready <= 1'b1;
            else begin
               mem_pend <= 1'b1;
               mem_cnt  <= mem_delay;
            end
         end else if (mem_pend) begin
            if (mem_cnt == 1) begin
               m_if.m_ready <= 1'b1;
               mem_pend     <= 1'b0;
            end
            mem_cnt <= mem_cnt - 1;
         end
      end
   end

   // ---------------- scoreboard state ----------------
   txn_t   drv0_q [$];
   txn_t   drv1_q [$];
   issue_t issue_q [$];
   logic [WIDTH-1:0] rd0_q [$];
   logic [WIDTH-1:0] rd1_q [$];
   logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: '0};
   logic [WIDTH-1:0] hold0 = '0;
   logic [WIDTH-1:0] hold1 = '0;
   int   cyc = 0;
   int   mv_count = 0;
   logic gap_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Queue a transaction on a requester's driver.
   task automatic q_txn(input logic p, input logic wr, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d);
      txn_t t;
      t.wr = wr; t.addr = a; t.data = d;
      if (p) drv1_q.push_back(t);
      else   drv0_q.push_back(t);
   endtask

   // Record the expected issue (in expected grant order) and completion data.
   task automatic exp_txn(input logic p, input logic wr, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d);
      issue_t e;
      e.port = p; e.wr = wr; e.addr = a; e.data = d;
      issue_q.push_back(e);
      if (wr) ref_mem[a] = d;
      else if (p) hold1 = ref_mem[a];
      else        hold0 = ref_mem[a];
      if (p) rd1_q.push_back(hold1);
      else   rd0_q.push_back(hold0);
   endtask

   function automatic int pending();
      return drv0_q.size() + drv1_q.size() + issue_q.size() + rd0_q.size() + rd1_q.size();
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((pending() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(pending()), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},     32'(busy), 0);
      check({tag, "_grant"},    32'(grant), 0);
      check({tag, "_m_valid"},  32'(m_if.m_valid), 0);
      check({tag, "_m_wr_rd"},  32'(m_if.m_wr_rd), 0);
      check({tag, "_m_addr"},   32'(m_if.m_addr), 0);
      check({tag, "_m_wdata"},  32'(m_if.m_wdata), 0);
      check({tag, "_s0_ready"}, 32'(s0_if.ready), 0);
      check({tag, "_s1_ready"}, 32'(s1_if.ready), 0);
      check({tag, "_s0_rdata"}, 32'(s0_if.rdata), 0);
      check({tag, "_s1_rdata"}, 32'(s1_if.rdata), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      res = 1'b0;
      repeat (2) @(negedge clk);
      res   = 1'b1;
      hold0 = '0;
      hold1 = '0;
   endtask

   // ---------------- requester drivers ----------------
   initial begin : drv0
      txn_t t;
      s0_if.valid = 1'b0; s0_if.wr_rd = 1'b0; s0_if.addr = '0; s0_if.wdata = '0;
      forever begin
         @(negedge clk);
         if (!res) begin
            drv0_q.delete();
            s0_if.valid = 1'b0;
         end else begin
            if (s0_if.valid && s0_if.ready) begin
               void'(drv0_q.pop_front());
               s0_if.valid = 1'b0;
            end
            if (!s0_if.valid && drv0_q.size() != 0) begin
               t = drv0_q[0];
               s0_if.valid = 1'b1; s0_if.wr_rd = t.wr; s0_if.addr = t.addr; s0_if.wdata = t.data;
            end
         end
      end
   end

   initial begin : drv1
      txn_t t;
      s1_if.valid = 1'b0; s1_if.wr_rd = 1'b0; s1_if.addr = '0; s1_if.wdata = '0;
      forever begin
         @(negedge clk);
         if (!res) begin
            drv1_q.delete();
            s1_if.valid = 1'b0;
         end else begin
            if (s1_if.valid && s1_if.ready) begin
               void'(drv1_q.pop_front());
               s1_if.valid = 1'b0;
            end
            if (!s1_if.valid && drv1_q.size() != 0) begin
               t = drv1_q[0];
               s1_if.valid = 1'b1; s1_if.wr_rd = t.wr; s1_if.addr = t.addr; s1_if.wdata = t.data;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      issue_t e;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] cur_rd0;
      logic [WIDTH-1:0] cur_rd1;
      logic prev_mv;
      int   issue_cyc;
      int   last_rdy;
      cur_rd0 = '0; cur_rd1 = '0; prev_mv = 1'b0; issue_cyc = 0; last_rdy = -1;
      forever begin
         @(negedge clk);
         if (!res) begin
            cur_rd0 = '0; cur_rd1 = '0; prev_mv = 1'b0; last_rdy = -1;
         end else begin
            if (m_if.m_valid) begin
               mv_count++;
               check("m_valid_single_cycle", 32'(prev_mv), 0);
               check("issue_expected", 32'(issue_q.size() != 0), 1);
               check("busy_on_issue", 32'(busy), 1);
               if (issue_q.size() != 0) begin
                  e = issue_q.pop_front();
                  check("grant", 32'(grant), 32'(e.port));
                  check("m_wr_rd", 32'(m_if.m_wr_rd), 32'(e.wr));
                  check("m_addr", 32'(m_if.m_addr), 32'(e.addr));
                  if (e.wr) check("m_wdata", 32'(m_if.m_wdata), 32'(e.data));
               end
               issue_cyc = cyc;
            end
            prev_mv = m_if.m_valid;

            if (s0_if.ready || s1_if.ready) begin
               check("one_ready_only", 32'(s0_if.ready && s1_if.ready), 0);
               check("latency", 32'(cyc - issue_cyc), 32'(2 + mem_delay));
               if (gap_chk && last_rdy >= 0) check("completion_gap", 32'(cyc - last_rdy), 4);
               last_rdy = gap_chk ? cyc : -1;
            end
            if (s0_if.ready) begin
               check("s0_ready_expected", 32'(rd0_q.size() != 0), 1);
               if (rd0_q.size() != 0) begin
                  r = rd0_q.pop_front();
                  check("s0_rdata", 32'(s0_if.rdata), 32'(r));
                  cur_rd0 = r;
               end
               check("s1_rdata_held", 32'(s1_if.rdata), 32'(cur_rd1));
            end
            if (s1_if.ready) begin
               check("s1_ready_expected", 32'(rd1_q.size() != 0), 1);
               if (rd1_q.size() != 0) begin
                  r = rd1_q.pop_front();
                  check("s1_rdata", 32'(s1_if.rdata), 32'(r));
                  cur_rd1 = r;
               end
               check("s0_rdata_held", 32'(s0_if.rdata), 32'(cur_rd0));
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin : main
      int mv0;
      int n;
      res = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      res = 1'b1;

      // Single write from port 0.
      sync();
      mv0 = mv_count;
      q_txn(0, 1, 5'd5, 16'hA5A5);
      exp_txn(0, 1, 5'd5, 16'hA5A5);
      drain("single_write_drain");
      check("single_write_pulses", 32'(mv_count - mv0), 1);
      check("idle_busy", 32'(busy), 0);

      // Cross-port read of the same word.
      sync();
      q_txn(1, 0, 5'd5, 16'h0000);
      exp_txn(1, 0, 5'd5, 16'h0000);
      drain("cross_read_drain");

      // Back-to-back on port 0: valid stays high across ready.
      sync();
      mv0 = mv_count;
      q_txn(0, 1, 5'd3, 16'h1111);
      q_txn(0, 0, 5'd3, 16'h0000);
      exp_txn(0, 1, 5'd3, 16'h1111);
      exp_txn(0, 0, 5'd3, 16'h0000);
      drain("b2b_drain");
      check("b2b_pulses", 32'(mv_count - mv0), 2);

      // Contention: both ports hold valid continuously.
      do_reset();
      gap_chk = 1'b1;
      sync();
      q_txn(0, 1, 5'd10, 16'h1234);
      q_txn(0, 0, 5'd10, 16'h0000);
      q_txn(0, 1, 5'd11, 16'h5678);
      q_txn(1, 0, 5'd3,  16'h0000);
      q_txn(1, 1, 5'd12, 16'h9ABC);
`ifdef MEM_ARB_RR_EN
      exp_txn(0, 1, 5'd10, 16'h1234);
      exp_txn(1, 0, 5'd3,  16'h0000);
      exp_txn(0, 0, 5'd10, 16'h0000);
      exp_txn(1, 1, 5'd12, 16'h9ABC);
      exp_txn(0, 1, 5'd11, 16'h5678);
`else
      exp_txn(0, 1, 5'd10, 16'h1234);
      exp_txn(0, 0, 5'd10, 16'h0000);
      exp_txn(0, 1, 5'd11, 16'h5678);
      exp_txn(1, 0, 5'd3,  16'h0000);
      exp_txn(1, 1, 5'd12, 16'h9ABC);
`endif
      drain("contention_drain");
      gap_chk = 1'b0;

      // Reset while waiting on a slow memory: read dropped, no ready pulse.
      mem_delay = 4;
      sync();
      begin
         issue_t e;
         e.port = 1'b0; e.wr = 1'b0; e.addr = 5'd10; e.data = '0;
         issue_q.push_back(e);
      end
      q_txn(0, 0, 5'd10, 16'h0000);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_if.m_valid && n < 20);
      check("mid_issue_seen", 32'(m_if.m_valid), 1);
      repeat (2) @(negedge clk);
      #2;
      check("mid_busy_in_wait", 32'(busy), 1);
      res = 1'b0;
      #1;
      check_zero("mid_reset");
      repeat (2) @(negedge clk);
      res       = 1'b1;
      hold0     = '0;
      hold1     = '0;
      mem_delay = 0;
      repeat (3) @(negedge clk);
      check("mid_no_activity", 32'(busy), 0);

      // Fresh port-1 read after the reset.
      sync();
      q_txn(1, 0, 5'd5, 16'h0000);
      exp_txn(1, 0, 5'd5, 16'h0000);
      drain("post_reset_drain");

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
